// File: rtl/pp_pipeline_accel_fifo_pkg.sv
// Shared helpers for the ring-buffer FIFO: pointer wrap and occupancy counter sizing.
package pp_pipeline_accel_fifo_pkg;

    // Wraps with an explicit compare so that any depth works, not only powers of two.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_ring_if.sv
// Stream, flow-control and status bundle between a FIFO and its producer/consumer.
interface pp_pipeline_accel_fifo_ring_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 1
);
    logic                  if_flush;
    logic                  if_write;
    logic                  if_write_ce;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic                  if_read_ce;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_num_data_valid;
    logic [ADDR_WIDTH:0]   if_fifo_cap;
    logic                  if_almost_full;
    logic                  if_almost_empty;
    logic                  if_overflow;
    logic                  if_underflow;

    modport slave (
        input  if_flush, if_write, if_write_ce, if_din, if_read, if_read_ce,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap,
               if_almost_full, if_almost_empty, if_overflow, if_underflow
    );

    modport master (
        output if_flush, if_write, if_write_ce, if_din, if_read, if_read_ce,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap,
               if_almost_full, if_almost_empty, if_overflow, if_underflow
    );
endinterface

// File: rtl/pp_pipeline_accel_fifo_ring_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module pp_pipeline_accel_fifo_ring_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pp_pipeline_accel_fifo_ring.sv
// First-word-fall-through ring FIFO with arbitrary depth, threshold flags and sticky error flags.
module pp_pipeline_accel_fifo_ring
    import pp_pipeline_accel_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    pp_pipeline_accel_fifo_ring_if.slave   bus
);
    localparam int CNT_W = count_width(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  empty_n;
    logic                  full_n;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_req;
    logic                  rd_req;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_req = bus.if_write & bus.if_write_ce;
    assign rd_req = bus.if_read & bus.if_read_ce;
    // Flush wins over both ports, so neither the memory nor the pointers move that cycle.
    assign wr_ok  = wr_req & full_n & ~bus.if_flush;
    assign rd_ok  = rd_req & empty_n & ~bus.if_flush;

    always_comb begin
        count_next = count;
        if (bus.if_flush) begin
            count_next = '0;
        end else if (wr_ok && !rd_ok) begin
            count_next = count + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            empty_n      <= 1'b0;
            full_n       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (bus.if_flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_ok) wptr <= ADDR_WIDTH'(ptr_inc(int'(wptr), DEPTH));
                if (rd_ok) rptr <= ADDR_WIDTH'(ptr_inc(int'(rptr), DEPTH));
            end
            count        <= count_next;
            empty_n      <= (count_next != '0);
            full_n       <= (count_next != CNT_W'(DEPTH));
            almost_full  <= (count_next >= CNT_W'(AF_LEVEL));
            almost_empty <= (count_next <= CNT_W'(AE_LEVEL));
        end
    end

    // Error flags record any rejected request and stay set until flush or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.if_flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req && !full_n)  overflow  <= 1'b1;
            if (rd_req && !empty_n) underflow <= 1'b1;
        end
    end

    pp_pipeline_accel_fifo_ring_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wptr),
        .wdata(bus.if_din),
        .raddr(rptr),
        .rdata(bus.if_dout)
    );

    assign bus.if_full_n         = full_n;
    assign bus.if_empty_n        = empty_n;
    assign bus.if_num_data_valid = count;
    assign bus.if_fifo_cap       = CNT_W'(DEPTH);
    assign bus.if_almost_full    = almost_full;
    assign bus.if_almost_empty   = almost_empty;
    assign bus.if_overflow       = overflow;
    assign bus.if_underflow      = underflow;
endmodule
